// File: rtl/cpu_multicycle.sv
// Multi-cycle core: FETCH/DECODE/EXECUTE/WRITEBACK with stallable fetch, shift/rotate ALU,
// integrated register file and a terminal illegal-opcode trap.
module cpu_multicycle #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 3,
   parameter int PC_W       = 32
) (
   input  logic                  CLK,
   input  logic                  RESET,
   output logic [PC_W-1:0]       PC,
   output logic                  IMEM_READ,
   input  logic                  IMEM_BUSY,
   input  logic [31:0]           INSTRUCTION,
   output logic                  RETIRED,
   output logic                  ILLEGAL,
   input  logic [REG_ADDR_W-1:0] DBG_ADDR,
   output logic [DATA_W-1:0]     DBG_DATA
);

   localparam int          NREGS = 2 ** REG_ADDR_W;
   localparam int unsigned DW    = DATA_W;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_TRAP
   } state_t;

   typedef enum logic [7:0] {
      OP_LOADI = 8'd0,  OP_MOV = 8'd1, OP_ADD = 8'd2,  OP_SUB = 8'd3,  OP_AND = 8'd4,
      OP_OR    = 8'd5,  OP_J   = 8'd6, OP_BEQ = 8'd7,  OP_BNE = 8'd8,  OP_SLL = 8'd9,
      OP_SRL   = 8'd10, OP_SRA = 8'd11, OP_ROR = 8'd12
   } op_t;

   state_t              state_q;
   logic [PC_W-1:0]     pc_q;
   logic [31:0]         ir_q;
   logic [DATA_W-1:0]   a_q, b_q, res_q;
   logic                zero_q, illegal_q, retired_q;
   logic [DATA_W-1:0]   regs_q [NREGS];

   logic [7:0]            opcode, sh;
   logic [REG_ADDR_W-1:0] rd_idx, rs1_idx, rs2_idx;
   logic [DATA_W-1:0]     imm, alu_d;
   logic [PC_W-1:0]       pc_plus4, pc_d, br_off;
   logic                  legal, is_write, take_br;
   int unsigned           rot;
   logic                  unused_ir;

   assign opcode    = ir_q[31:24];
   assign rd_idx    = ir_q[16 +: REG_ADDR_W];
   assign rs1_idx   = ir_q[8 +: REG_ADDR_W];
   assign rs2_idx   = ir_q[0 +: REG_ADDR_W];
   assign sh        = ir_q[7:0];
   assign imm       = DATA_W'(signed'(ir_q[7:0]));
   assign br_off    = PC_W'(signed'(ir_q[23:16]));
   assign unused_ir = ^ir_q[15:0];

   assign legal    = (opcode <= 8'd12);
   assign is_write = !(opcode == OP_J || opcode == OP_BEQ || opcode == OP_BNE);
   assign take_br  = (opcode == OP_J) || (opcode == OP_BEQ && zero_q) || (opcode == OP_BNE && !zero_q);
   assign pc_plus4 = pc_q + PC_W'(4);
   assign pc_d     = take_br ? pc_plus4 + (br_off << 2) : pc_plus4;

   always_comb begin
      alu_d = '0;
      rot   = 32'(sh) % DW;
      case (opcode)
         OP_LOADI: alu_d = imm;
         OP_MOV:   alu_d = b_q;
         OP_ADD:   alu_d = a_q + b_q;
         OP_SUB:   alu_d = a_q - b_q;
         OP_AND:   alu_d = a_q & b_q;
         OP_OR:    alu_d = a_q | b_q;
         OP_SLL:   alu_d = (32'(sh) >= DW) ? '0 : a_q << sh;
         OP_SRL:   alu_d = (32'(sh) >= DW) ? '0 : a_q >> sh;
         OP_SRA:   alu_d = (32'(sh) >= DW) ? {DATA_W{a_q[DATA_W-1]}} : DATA_W'($signed(a_q) >>> sh);
         // rot==0 shifts the left term by DATA_W, which yields zero and leaves A intact
         OP_ROR:   alu_d = (a_q >> rot) | (a_q << (DW - rot));
         default:  alu_d = '0;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_FETCH;
         pc_q      <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= 1'b0;
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         retired_q <= 1'b0;
         case (state_q)
            S_FETCH: begin
               if (!IMEM_BUSY) begin
                  ir_q    <= INSTRUCTION;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (legal) begin
                  a_q     <= regs_q[rs1_idx];
                  b_q     <= regs_q[rs2_idx];
                  state_q <= S_EXECUTE;
               end else begin
                  illegal_q <= 1'b1;
                  state_q   <= S_TRAP;
               end
            end
            S_EXECUTE: begin
               res_q     <= alu_d;
               zero_q    <= (a_q == b_q);
               retired_q <= 1'b1;
               state_q   <= S_WRITEBACK;
            end
            S_WRITEBACK: begin
               if (is_write) regs_q[rd_idx] <= res_q;
               pc_q    <= pc_d;
               state_q <= S_FETCH;
            end
            S_TRAP:  state_q <= S_TRAP;
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign PC        = pc_q;
   assign IMEM_READ = (state_q == S_FETCH) & ~RESET;
   assign RETIRED   = retired_q;
   assign ILLEGAL   = illegal_q;
   assign DBG_DATA  = regs_q[DBG_ADDR];

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: program images, a retire-PC scoreboard and
// register/flag checks for both an 8-bit and a 16-bit instance.
module tb_cpu_multicycle;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        RST16 = 1'b1;
   logic        IMEM_BUSY = 1'b0;
   logic [2:0]  DBG_ADDR = '0;
   logic [31:0] PC, PC16, INSTRUCTION, INSTR16;
   logic        IMEM_READ, RETIRED, ILLEGAL, IMEM_READ16, RETIRED16, ILLEGAL16;
   logic [7:0]  DBG_DATA;
   logic [15:0] DBG_DATA16;

   logic [31:0] mem   [64];
   logic [31:0] mem16 [64];
   int unsigned exp_q [$];
   int          errors = 0;
   int          checks = 0;

   always #5 CLK = ~CLK;

   assign INSTRUCTION = mem[PC[7:2]];
   assign INSTR16     = mem16[PC16[7:2]];

   cpu_multicycle #(.DATA_W(8), .REG_ADDR_W(3), .PC_W(32)) dut (
      .CLK(CLK), .RESET(RESET), .PC(PC), .IMEM_READ(IMEM_READ), .IMEM_BUSY(IMEM_BUSY),
      .INSTRUCTION(INSTRUCTION), .RETIRED(RETIRED), .ILLEGAL(ILLEGAL),
      .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
   );

   cpu_multicycle #(.DATA_W(16), .REG_ADDR_W(3), .PC_W(32)) dut16 (
      .CLK(CLK), .RESET(RST16), .PC(PC16), .IMEM_READ(IMEM_READ16), .IMEM_BUSY(1'b0),
      .INSTRUCTION(INSTR16), .RETIRED(RETIRED16), .ILLEGAL(ILLEGAL16),
      .DBG_ADDR(3'd1), .DBG_DATA(DBG_DATA16)
   );

   function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] rd,
                                       input logic [7:0] rs1, input logic [7:0] rs2);
      return {op, rd, rs1, rs2};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reg_is(input string tag, input logic [2:0] a, input logic [31:0] exp);
      DBG_ADDR = a;
      #1;
      check(tag, {24'd0, DBG_DATA}, exp);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = '0;
      exp_q.delete();
   endtask

   // Reset is applied and released on falling edges; program must already be loaded.
   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   // Waits for the next retire pulse and checks the retiring PC against the scoreboard.
   task automatic drain(input string tag, output int cyc);
      int unsigned exp;
      cyc = 0;
      do begin
         @(negedge CLK);
         cyc++;
      end while (!RETIRED && cyc < 40);
      if (!RETIRED) begin
         check({tag, " retire timeout"}, {31'd0, RETIRED}, 32'd1);
         return;
      end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check({tag, " retire pc"}, PC, exp);
   endtask

   initial begin
      int cyc, seen;
      for (int i = 0; i < 64; i++) mem16[i] = '0;
      mem16[0] = ins(8'd0, 8'd1, 8'd0, 8'd1);      // loadi r1,1
      mem16[1] = ins(8'd12, 8'd1, 8'd1, 8'd1);     // ror r1,r1,1

      // reset state
      clear_mem();
      @(negedge CLK);
      check("rst pc", PC, 32'd0);
      check("rst imem_read", {31'd0, IMEM_READ}, 32'd0);
      check("rst retired", {31'd0, RETIRED}, 32'd0);
      check("rst illegal", {31'd0, ILLEGAL}, 32'd0);
      reg_is("rst r3", 3'd3, 32'd0);

      // T1: loadi/loadi/add then and/or/mov
      clear_mem();
      mem[0] = ins(8'd0, 8'd1, 8'd0, 8'd5);
      mem[1] = ins(8'd0, 8'd2, 8'd0, 8'd3);
      mem[2] = ins(8'd2, 8'd3, 8'd1, 8'd2);
      mem[3] = ins(8'd4, 8'd4, 8'd1, 8'd2);
      mem[4] = ins(8'd5, 8'd5, 8'd1, 8'd2);
      mem[5] = ins(8'd1, 8'd6, 8'd2, 8'd1);
      for (int i = 0; i < 6; i++) exp_q.push_back(4 * i);
      do_reset();
      drain("t1 i0", cyc);
      check("t1 first latency", cyc, 32'd3);
      drain("t1 i1", cyc);
      check("t1 latency", cyc, 32'd4);
      drain("t1 i2", cyc);
      reg_is("t1 r3 old during wb", 3'd3, 32'd0);
      @(negedge CLK);
      check("t1 pc", PC, 32'd12);
      reg_is("t1 r3", 3'd3, 32'd8);
      for (int i = 0; i < 3; i++) drain("t1 logic", cyc);
      @(negedge CLK);
      reg_is("t1 and", 3'd4, 32'd1);
      reg_is("t1 or", 3'd5, 32'd7);
      reg_is("t1 mov", 3'd6, 32'd5);

      // T2: sub wrap and shift boundaries
      clear_mem();
      mem[0] = ins(8'd0, 8'd1, 8'd0, 8'd3);
      mem[1] = ins(8'd0, 8'd2, 8'd0, 8'd5);
      mem[2] = ins(8'd3, 8'd3, 8'd1, 8'd2);
      mem[3] = ins(8'd11, 8'd4, 8'd3, 8'd1);
      mem[4] = ins(8'd9, 8'd5, 8'd3, 8'd8);
      mem[5] = ins(8'd10, 8'd6, 8'd3, 8'd1);
      mem[6] = ins(8'd11, 8'd7, 8'd3, 8'd200);
      mem[7] = ins(8'd12, 8'd0, 8'd1, 8'd9);
      for (int i = 0; i < 8; i++) exp_q.push_back(4 * i);
      do_reset();
      for (int i = 0; i < 8; i++) drain("t2", cyc);
      @(negedge CLK);
      reg_is("t2 sub", 3'd3, 32'hFE);
      reg_is("t2 sra1", 3'd4, 32'hFF);
      reg_is("t2 sll8", 3'd5, 32'h00);
      reg_is("t2 srl1", 3'd6, 32'h7F);
      reg_is("t2 sra200", 3'd7, 32'hFF);
      reg_is("t2 ror9", 3'd0, 32'h81);

      // T3a: beq taken, bne not taken
      clear_mem();
      mem[0] = ins(8'd0, 8'd1, 8'd0, 8'd7);
      mem[1] = ins(8'd0, 8'd2, 8'd0, 8'd7);
      mem[2] = ins(8'd7, 8'd2, 8'd1, 8'd2);
      mem[5] = ins(8'd8, 8'd3, 8'd1, 8'd2);
      exp_q = '{0, 4, 8, 20};
      do_reset();
      for (int i = 0; i < 4; i++) drain("t3a", cyc);
      @(negedge CLK);
      check("t3a pc", PC, 32'd24);
      reg_is("t3a offset not written", 3'd2, 32'd7);

      // T3b: bne taken, j backward, beq not taken
      clear_mem();
      mem[0] = ins(8'd0, 8'd1, 8'd0, 8'd7);
      mem[1] = ins(8'd0, 8'd2, 8'd0, 8'd6);
      mem[2] = ins(8'd8, 8'd1, 8'd1, 8'd2);
      mem[4] = ins(8'd6, 8'hFE, 8'd0, 8'd0);
      mem[3] = ins(8'd7, 8'd5, 8'd1, 8'd2);
      exp_q = '{0, 4, 8, 16, 12};
      do_reset();
      for (int i = 0; i < 5; i++) drain("t3b", cyc);
      @(negedge CLK);
      check("t3b pc", PC, 32'd16);

      // T3c: j offset -2 at PC=8
      clear_mem();
      mem[0] = ins(8'd0, 8'd1, 8'd0, 8'd1);
      mem[1] = ins(8'd0, 8'd2, 8'd0, 8'd2);
      mem[2] = ins(8'd6, 8'hFE, 8'd0, 8'd0);
      exp_q = '{0, 4, 8};
      do_reset();
      for (int i = 0; i < 3; i++) drain("t3c", cyc);
      @(negedge CLK);
      check("t3c pc", PC, 32'd4);

      // T4: three stalled fetch cycles
      clear_mem();
      mem[0] = ins(8'd0, 8'd1, 8'd0, 8'd9);
      exp_q = '{0};
      IMEM_BUSY = 1'b1;
      do_reset();
      seen = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge CLK);
         if (IMEM_READ !== 1'b1 || PC !== 32'd0 || RETIRED !== 1'b0) seen++;
      end
      check("t4 stall hold", seen, 32'd0);
      IMEM_BUSY = 1'b0;
      drain("t4", cyc);
      check("t4 retire cycle", cyc + 3 + 1, 32'd7);

      // T5: illegal opcode trap
      clear_mem();
      mem[0] = ins(8'd0, 8'd1, 8'd0, 8'd9);
      mem[1] = ins(8'hFF, 8'd1, 8'd0, 8'd0);
      mem[2] = ins(8'd0, 8'd1, 8'd0, 8'd1);
      exp_q = '{0};
      do_reset();
      drain("t5", cyc);
      repeat (3) @(negedge CLK);
      seen = 0;
      repeat (12) begin
         @(negedge CLK);
         if (RETIRED || IMEM_READ || PC !== 32'd4) seen++;
      end
      check("t5 trap quiet", seen, 32'd0);
      check("t5 illegal", {31'd0, ILLEGAL}, 32'd1);
      reg_is("t5 r1 kept", 3'd1, 32'd9);
      RESET = 1'b1;
      #1;
      check("t5 reset clears illegal", {31'd0, ILLEGAL}, 32'd0);
      check("t5 imem_read in reset", {31'd0, IMEM_READ}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("t5 fetch after reset", {31'd0, IMEM_READ}, 32'd1);

      // T6a: reset mid-EXECUTE of add
      clear_mem();
      mem[0] = ins(8'd0, 8'd1, 8'd0, 8'd5);
      mem[1] = ins(8'd0, 8'd2, 8'd0, 8'd3);
      mem[2] = ins(8'd2, 8'd3, 8'd1, 8'd2);
      exp_q = '{0, 4};
      do_reset();
      drain("t6", cyc);
      drain("t6", cyc);
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      #1;
      check("t6 pc reset", PC, 32'd0);
      check("t6 retired reset", {31'd0, RETIRED}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("t6 imem_read", {31'd0, IMEM_READ}, 32'd1);
      reg_is("t6 r3 unwritten", 3'd3, 32'd0);

      // T6b: 16-bit rotate
      @(negedge CLK);
      RST16 = 1'b0;
      repeat (10) @(negedge CLK);
      check("t6 ror16", {16'd0, DBG_DATA16}, 32'h8000);
      check("t6 illegal16", {31'd0, ILLEGAL16}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
